lu_vector_sequencer: RTL and testbench
======================================

LU_VECTOR_SEQUENCER -- requirements
Module: lu_vector_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter SHALL be: SETTLE_CYC, default 1, number of cycles each vector is held before sampling (legal range 1-15).
REQ-003 Port SHALL be: clk  in  1  rising-edge clock.
REQ-004 Port SHALL be: reset  in  1  synchronous active-high reset.
REQ-005 Port SHALL be: start  in  1  request to run one full vector sweep.
REQ-006 Port SHALL be: a  out  1  operand A driven to the AND/NAND logic unit.
REQ-007 Port SHALL be: b  out  1  operand B driven to the logic unit.
REQ-008 Port SHALL be: sel  out  1  function select to the logic unit (0 = NAND, 1 = AND).
REQ-009 Port SHALL be: lu_out  in  1  selected result returned by the logic unit.
REQ-010 Port SHALL be: lu_and  in  1  parallel AND result returned by the logic unit.
REQ-011 Port SHALL be: lu_nand  in  1  parallel NAND result returned by the logic unit.
REQ-012 Port SHALL be: busy  out  1  high while a sweep is in progress.
REQ-013 Port SHALL be: done  out  1  one-cycle pulse at the end of a sweep.
REQ-014 Port SHALL be: pass  out  1  high when the last completed sweep had zero mismatches.
REQ-015 Port SHALL be: err_count  out  4  number of mismatching vectors in the current or last sweep.
REQ-016 Port SHALL be: vec_idx  out  3  index of the vector currently applied.

Function
REQ-017 The FSM SHALL have four states: IDLE, SETTLE, SAMPLE and DONE.
REQ-018 Operands SHALL be decoded from vec_idx as a = vec_idx[2], b = vec_idx[1] and sel = vec_idx[0].
REQ-019 In IDLE and DONE, a, b and sel SHALL be driven to 0.
REQ-020 In IDLE with start=1, at the same edge the block SHALL clear vec_idx, err_count and pass, load the settle counter, and enter SETTLE.
REQ-021 The block SHALL remain in SETTLE for exactly SETTLE_CYC cycles and then enter SAMPLE.
REQ-022 The expected values SHALL be: exp_and = a&b, exp_nand = ~(a&b), exp_out = sel ? exp_and : exp_nand.
REQ-023 In SAMPLE, err_count SHALL be incremented by 1 if any of lu_out, lu_and or lu_nand differs from its expected value, with at most one increment per vector.
REQ-024 At the end of SAMPLE, if vec_idx = 7 the block SHALL enter DONE; otherwise it SHALL increment vec_idx and enter SETTLE.
REQ-025 vec_idx SHALL never wrap during a sweep.
REQ-026 err_count SHALL be at most 8, so no saturation logic is required.
REQ-027 In DONE, the block SHALL assert done for exactly one cycle, set pass = (err_count == 0), and return to IDLE on the next edge.
REQ-028 busy SHALL be 1 in SETTLE and SAMPLE, and 0 in IDLE and DONE.
REQ-029 Sweep length SHALL be 8 × (SETTLE_CYC + 1) cycles from the start-accepting edge to the DONE-entering edge (16 cycles for the default).
REQ-030 start SHALL be ignored in SETTLE, SAMPLE and DONE, with no restart and no queuing.
REQ-031 pass, err_count and vec_idx SHALL hold their values after DONE until the next accepted start or reset.
REQ-032 All outputs SHALL be registered or decoded only from state and vec_idx, with no combinational path from lu_* inputs to any output.

Reset
REQ-033 When reset=1 at a clock edge, the state SHALL become IDLE and vec_idx, err_count, pass, done, busy, a, b, sel and the settle counter SHALL all become 0.
REQ-034 Reset SHALL take priority over start and over any in-progress sweep, with no done pulse emitted for an aborted sweep.

Verification
REQ-035 Scenario, golden LU, SETTLE_CYC=1: reset, then start pulse -> (a,b,sel) steps through 000..111, done pulses 16 cycles after the accepting edge, err_count=0, pass=1.
REQ-036 Scenario, lu_nand stuck at 0, other lu_* golden: -> vectors 0-5 mismatch, err_count=6, pass=0.
REQ-037 Scenario, all three lu_* inputs inverted from golden: -> err_count=8, pass=0, exactly one done pulse.
REQ-038 Scenario, start held high for the whole sweep, golden LU: -> one sweep only, single done pulse, then a new sweep starts on the cycle after return to IDLE.
REQ-039 Scenario, reset asserted on the 7th cycle of a sweep: -> next cycle busy=0, a=b=sel=0, err_count=0, pass=0, no done; a following start runs a full 8-vector sweep.
REQ-040 Scenario, SETTLE_CYC=3, golden LU: -> each vector held for 3 cycles before sampling, done 32 cycles after the accepting edge, pass=1.

Source files
------------

// File: rtl/lu_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lu_vector_sequencer
// Brief    : Applies all eight (a,b,sel) vectors to an AND/NAND logic unit,
//            checks the returned results and reports a pass/fail summary.
// Revision : 1.0 - initial release
// ============================================================================
module lu_vector_sequencer #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       sel,
    input  logic       lu_out,
    input  logic       lu_and,
    input  logic       lu_nand,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] vec_idx
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);
    localparam logic [2:0] LAST_VEC    = 3'd7;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] settle_cnt;
    logic [3:0] settle_cnt_nxt;
    logic [2:0] vec_idx_nxt;
    logic [3:0] err_count_nxt;
    logic       pass_nxt;

    logic       exp_and;
    logic       exp_nand;
    logic       exp_out;
    logic       mismatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            settle_cnt <= 4'd0;
            vec_idx    <= 3'd0;
            err_count  <= 4'd0;
            pass       <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            vec_idx    <= vec_idx_nxt;
            err_count  <= err_count_nxt;
            pass       <= pass_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        vec_idx_nxt    = vec_idx;
        err_count_nxt  = err_count;
        pass_nxt       = pass;
        a              = 1'b0;
        b              = 1'b0;
        sel            = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;

        // Expected results come from vec_idx so lu_* only ever feed registers.
        exp_and  = vec_idx[2] & vec_idx[1];
        exp_nand = ~exp_and;
        exp_out  = vec_idx[0] ? exp_and : exp_nand;
        mismatch = (lu_out != exp_out) | (lu_and != exp_and) | (lu_nand != exp_nand);

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt      = ST_SETTLE;
                    settle_cnt_nxt = SETTLE_LOAD;
                    vec_idx_nxt    = 3'd0;
                    err_count_nxt  = 4'd0;
                    pass_nxt       = 1'b0;
                end
            end

            ST_SETTLE: begin
                a    = vec_idx[2];
                b    = vec_idx[1];
                sel  = vec_idx[0];
                busy = 1'b1;
                if (settle_cnt <= 4'd1) begin
                    state_nxt      = ST_SAMPLE;
                    settle_cnt_nxt = 4'd0;
                end else begin
                    settle_cnt_nxt = settle_cnt - 4'd1;
                end
            end

            ST_SAMPLE: begin
                a    = vec_idx[2];
                b    = vec_idx[1];
                sel  = vec_idx[0];
                busy = 1'b1;
                if (mismatch) begin
                    err_count_nxt = err_count + 4'd1;
                end
                // Pass is settled on the DONE-entering edge so it is valid alongside done.
                if (vec_idx == LAST_VEC) begin
                    state_nxt = ST_DONE;
                    pass_nxt  = (err_count_nxt == 4'd0);
                end else begin
                    state_nxt      = ST_SETTLE;
                    vec_idx_nxt    = vec_idx + 3'd1;
                    settle_cnt_nxt = SETTLE_LOAD;
                end
            end

            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lu_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lu_vector_sequencer
// Brief    : Directed bench for lu_vector_sequencer with a fault-injectable LU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lu_vector_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic start1, start3;
    logic which;        // 0 selects the SETTLE_CYC=1 instance, 1 the SETTLE_CYC=3 one
    int   mode;         // 0 golden, 1 lu_nand stuck at 0, 2 all results inverted

    logic a1, b1, sel1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [2:0] vec1;
    logic a3, b3, sel3, busy3, done3, pass3;
    logic [3:0] err3;
    logic [2:0] vec3;

    logic lu_out1, lu_and1, lu_nand1;
    logic lu_out3, lu_and3, lu_nand3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        lu_and1  = (a1 & b1) ^ (mode == 2);
        lu_nand1 = (mode == 1) ? 1'b0 : (~(a1 & b1) ^ (mode == 2));
        lu_out1  = (sel1 ? (a1 & b1) : ~(a1 & b1)) ^ (mode == 2);
        lu_and3  = (a3 & b3) ^ (mode == 2);
        lu_nand3 = (mode == 1) ? 1'b0 : (~(a3 & b3) ^ (mode == 2));
        lu_out3  = (sel3 ? (a3 & b3) : ~(a3 & b3)) ^ (mode == 2);
    end

    lu_vector_sequencer u_dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .a(a1), .b(b1), .sel(sel1),
        .lu_out(lu_out1), .lu_and(lu_and1), .lu_nand(lu_nand1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .vec_idx(vec1)
    );

    lu_vector_sequencer #(.SETTLE_CYC(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3),
        .a(a3), .b(b3), .sel(sel3),
        .lu_out(lu_out3), .lu_and(lu_and3), .lu_nand(lu_nand3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .vec_idx(vec3)
    );

    wire       o_a    = which ? a3    : a1;
    wire       o_b    = which ? b3    : b1;
    wire       o_sel  = which ? sel3  : sel1;
    wire       o_busy = which ? busy3 : busy1;
    wire       o_done = which ? done3 : done1;
    wire [2:0] o_vec  = which ? vec3  : vec1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Launches a sweep and returns the cycle (0 = accepting edge) at which done is seen,
    // plus the number of cycles whose applied vector did not match n/(SETTLE_CYC+1).
    task automatic run_sweep(input bit use3, input bit hold, output int done_n, output int seq_bad);
        int s;
        int total;
        logic [2:0] expv;
        s       = use3 ? 3 : 1;
        total   = 8 * (s + 1);
        which   = use3;
        seq_bad = 0;
        done_n  = -1;
        @(negedge clk);
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        for (int n = 0; (n <= total + 8) && (done_n < 0); n++) begin
            @(negedge clk);
            if (!hold) begin
                start1 = 1'b0;
                start3 = 1'b0;
            end
            if (o_done) begin
                done_n = n;
            end else if (n < total) begin
                expv = 3'(n / (s + 1));
                if (o_vec !== expv || {o_a, o_b, o_sel} !== expv || o_busy !== 1'b1)
                    seq_bad++;
            end
        end
    endtask

    initial begin
        int dn;
        int sb;
        int pulses;
        reset  = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        which  = 1'b0;
        mode   = 0;
        repeat (3) @(negedge clk);

        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_pass", pass1, 0);
        chk("rst_err", err1, 0);
        chk("rst_vec", vec1, 0);
        chk("rst_abs", {a1, b1, sel1}, 0);
        chk("rst_busy3", busy3, 0);
        reset = 1'b0;

        // Golden sweep, default settle
        run_sweep(0, 0, dn, sb);
        chk("gold_done_cyc", dn, 16);
        chk("gold_seq", sb, 0);
        chk("gold_err", err1, 0);
        chk("gold_pass", pass1, 1);
        chk("gold_abs_done", {a1, b1, sel1}, 0);
        @(negedge clk);
        chk("gold_done_pulse", done1, 0);
        chk("gold_idle_busy", busy1, 0);
        repeat (3) @(negedge clk);
        chk("gold_hold_vec", vec1, 7);
        chk("gold_hold_pass", pass1, 1);

        // lu_nand stuck at 0: vectors 0-5 expect nand=1
        mode = 1;
        run_sweep(0, 0, dn, sb);
        chk("nand0_done_cyc", dn, 16);
        chk("nand0_err", err1, 6);
        chk("nand0_pass", pass1, 0);

        // All results inverted: every vector mismatches once
        mode = 2;
        run_sweep(0, 0, dn, sb);
        chk("inv_err", err1, 8);
        chk("inv_pass", pass1, 0);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (done1) pulses++;
        end
        chk("inv_extra_done", pulses, 0);
        chk("inv_hold_err", err1, 8);

        // Start held through the sweep
        mode = 0;
        run_sweep(0, 1, dn, sb);
        chk("hold_done_cyc", dn, 16);
        chk("hold_seq", sb, 0);
        @(negedge clk);
        chk("hold_idle_busy", busy1, 0);
        chk("hold_idle_done", done1, 0);
        chk("hold_idle_pass", pass1, 1);
        @(negedge clk);
        chk("hold_restart_busy", busy1, 1);
        chk("hold_restart_vec", vec1, 0);
        chk("hold_restart_pass", pass1, 0);
        start1 = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset  = 1'b0;

        // Reset on the 7th cycle of a faulty sweep
        mode   = 2;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_err_before", err1, 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy1, 0);
        chk("abort_abs", {a1, b1, sel1}, 0);
        chk("abort_err", err1, 0);
        chk("abort_pass", pass1, 0);
        chk("abort_vec", vec1, 0);
        pulses = (done1 === 1'b1) ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            if (done1 || busy1) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        mode = 0;
        run_sweep(0, 0, dn, sb);
        chk("after_abort_done_cyc", dn, 16);
        chk("after_abort_seq", sb, 0);
        chk("after_abort_pass", pass1, 1);

        // SETTLE_CYC = 3 instance
        run_sweep(1, 0, dn, sb);
        chk("s3_done_cyc", dn, 32);
        chk("s3_seq", sb, 0);
        chk("s3_err", err3, 0);
        chk("s3_pass", pass3, 1);
        chk("s3_idle_dut1", busy1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
